// File: rtl/branch_predict_unit_pkg.sv
// Shared branch-unit defines: BR_* condition codes, pcsrc encodings and branch-op codes.
package branch_predict_unit_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    localparam logic [1:0] PCSRC_PC4     = 2'b00;
    localparam logic [1:0] PCSRC_IMM     = 2'b01;
    localparam logic [1:0] PCSRC_ALU     = 2'b10;
    localparam logic [1:0] PCSRC_RECOVER = 2'b11;

    typedef enum logic [1:0] {
        OP_NONE   = 2'b00,
        OP_BRANCH = 2'b01,
        OP_JAL    = 2'b10,
        OP_JALR   = 2'b11
    } branch_op_e;

    // Reserved funct3 codes resolve as not taken.
    function automatic logic br_cond(input logic [2:0] funct3, input logic zf,
                                     input logic cf, input logic sf, input logic vf);
        logic c;
        c = 1'b0;
        case (funct3)
            BR_BEQ:  c = zf;
            BR_BNE:  c = !zf;
            BR_BLT:  c = (sf != vf);
            BR_BGE:  c = (sf == vf);
            BR_BLTU: c = !cf;
            BR_BGEU: c = cf;
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter.sv
// Saturating up/down counter, one per BHT entry; resets to weakly-not-taken.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CTR_W-1:0] value
);
    localparam logic [CTR_W-1:0] WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

    logic [CTR_W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (inc && (value_q != '1)) begin
            value_d = value_q + CTR_W'(1);
        end else if (dec && (value_q != '0)) begin
            value_d = value_q - CTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= WEAK_NT;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor with EX-stage resolution and redirect select.
// Optional performance counters are built when BPU_PERF_CNT_EN is defined.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CTR_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [1:0]      ex_branchOp,
    input  logic [2:0]      ex_funct3,
    input  logic            zf,
    input  logic            cf,
    input  logic            sf,
    input  logic            vf,
    input  logic            ex_pred_taken,
    output logic [1:0]      pcsrc,
    output logic            ex_taken,
    output logic            mispredict,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispred
);
    localparam int ENTRIES = 1 << IDX_W;

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [CTR_W-1:0] bht_val [ENTRIES];
    logic             is_br, cond;
    logic             unused_pc_bits;

    assign if_idx = if_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                              ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

    assign is_br      = ex_valid && (ex_branchOp == OP_BRANCH);
    assign cond       = br_cond(ex_funct3, zf, cf, sf, vf);
    assign ex_taken   = is_br && cond;
    assign mispredict = is_br && (cond != ex_pred_taken);

    // Read is the registered value, so a same-cycle update is not bypassed.
    assign if_pred_taken = bht_val[if_idx][CTR_W-1];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
        sat_counter #(.CTR_W(CTR_W)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (is_br && cond && (ex_idx == IDX_W'(i))),
            .dec   (is_br && !cond && (ex_idx == IDX_W'(i))),
            .value (bht_val[i])
        );
    end

    always_comb begin
        pcsrc = PCSRC_PC4;
        if (ex_valid) begin
            case (ex_branchOp)
                OP_BRANCH: begin
                    if (cond && !ex_pred_taken) begin
                        pcsrc = PCSRC_IMM;
                    end else if (!cond && ex_pred_taken) begin
                        pcsrc = PCSRC_RECOVER;
                    end
                end
                OP_JAL:  pcsrc = PCSRC_IMM;
                OP_JALR: pcsrc = PCSRC_ALU;
                default: pcsrc = PCSRC_PC4;
            endcase
        end
    end

`ifdef BPU_PERF_CNT_EN
    logic [31:0] perf_branches_q, perf_branches_d;
    logic [31:0] perf_mispred_q, perf_mispred_d;

    always_comb begin
        perf_branches_d = perf_branches_q;
        perf_mispred_d  = perf_mispred_q;
        if (is_br) begin
            perf_branches_d = perf_branches_q + 32'd1;
        end
        if (mispredict) begin
            perf_mispred_d = perf_mispred_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q <= '0;
            perf_mispred_q  <= '0;
        end else begin
            perf_branches_q <= perf_branches_d;
            perf_mispred_q  <= perf_mispred_d;
        end
    end

    assign perf_branches = perf_branches_q;
    assign perf_mispred  = perf_mispred_q;
`else
    assign perf_branches = '0;
    assign perf_mispred  = '0;
`endif

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: PC width.
REQ-002 SHALL have parameter IDX_W, default 6: BHT index width, giving 2^IDX_W entries.
REQ-003 SHALL have parameter CTR_W, default 2: saturating counter width, with 2 <= CTR_W <= 4.
REQ-004 SHALL have ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  XLEN  fetch PC for prediction lookup.
- if_pred_taken  out  1  prediction for if_pc.
- ex_valid  in  1  EX-stage instruction valid.
- ex_pc  in  XLEN  PC of the EX-stage instruction.
- ex_branchOp  in  2  00 none, 01 conditional branch, 10 JAL, 11 JALR.
- ex_funct3  in  3  branch condition, using the shared BR_* codes.
- zf, cf, sf, vf  in  1 each  ALU flags for the EX instruction.
- ex_pred_taken  in  1  prediction carried down the pipe with the EX instruction.
- pcsrc  out  2  00 PC+4, 01 PC+Imm, 10 ALU result, 11 ex_pc+4 (recovery).
- ex_taken  out  1  resolved branch outcome.
- mispredict  out  1  flush request for younger instructions.
- perf_branches  out  32  resolved conditional-branch count (REQ-019 only).
- perf_mispred  out  32  mispredict count (REQ-019 only).

Function
REQ-005 SHALL form the index as pc[IDX_W+1:2] for both if_pc and ex_pc.
REQ-006 SHALL drive if_pred_taken combinationally as the MSB of BHT[index(if_pc)].
REQ-007 SHALL resolve the condition combinationally:
- BEQ: zf
- BNE: !zf
- BLT: sf!=vf
- BGE: sf==vf
- BLTU: !cf
- BGEU: cf
- funct3 010/011: not taken; no latch inferred.
REQ-008 SHALL drive ex_taken high only when ex_valid, ex_branchOp==01 and the condition is true.
REQ-009 SHALL drive mispredict high only when ex_valid, ex_branchOp==01 and ex_taken!=ex_pred_taken; it SHALL be 0 for JAL and JALR.
REQ-010 SHALL drive pcsrc from this table:
- ex_valid=0 or op 00: 00.
- op 01, taken and predicted taken: 00 (fetch already redirected).
- op 01, taken and predicted not-taken: 01.
- op 01, not taken and predicted taken: 11.
- op 01, not taken and predicted not-taken: 00.
- JAL: 01.
- JALR: 10.
REQ-011 SHALL update BHT[index(ex_pc)] on the clock edge after a valid op-01 cycle: +1 if taken, -1 if not taken, saturating at all-ones and at zero.
REQ-012 SHALL leave the BHT unchanged for ex_valid=0, op 00, JAL and JALR.
REQ-013 SHALL return the pre-update counter value on if_pred_taken when if_pc and ex_pc collide in the same cycle (no bypass); the new value SHALL be visible from the next cycle.
REQ-014 SHALL keep all pcsrc, ex_taken and mispredict outputs combinational (zero latency) and all counter updates one-cycle latency.

Reset
REQ-015 SHALL, while rst_n=0, set every BHT entry to weakly-not-taken, i.e. MSB=0 and the remaining bits all 1 (01 for CTR_W=2).
REQ-016 SHALL, while rst_n=0, clear perf_branches and perf_mispred to 0.
REQ-017 SHALL abandon any pending update when reset is asserted mid-operation; the first update after rst_n rises SHALL occur on the first valid edge.
REQ-018 SHALL ensure no output depends on X after reset, including if_pred_taken=0 for every index.

Configuration
REQ-019 SHALL compile perf_branches and perf_mispred as counters only when macro BPU_PERF_CNT_EN is defined:
- perf_branches increments once per valid op-01 cycle.
- perf_mispred increments once per mispredict cycle.
- Both wrap from 2^32-1 to 0.
- Without the macro, both outputs are tied to 0 and no counter flops exist.

Structure
REQ-020 SHALL take the BR_* funct3 codes and the pcsrc encodings (PCSRC_PC4, PCSRC_IMM, PCSRC_ALU, PCSRC_RECOVER) from the shared defines file.
REQ-021 SHALL implement the counter as one sub-module, sat_counter (parameter CTR_W; inputs inc/dec; output value), replicated per BHT entry, or share one update instance over a flop array.

Verification
REQ-022 SHALL cover reset plus lookup: after reset, if_pc=0x40 gives if_pred_taken=0.
REQ-023 SHALL cover training: BEQ at ex_pc=0x40 with zf=1 and ex_pred_taken=0 gives pcsrc=01 and mispredict=1; the next cycle, if_pc=0x40 gives if_pred_taken=1.
REQ-024 SHALL cover recovery: ex_pred_taken=1 with BNE and zf=1 gives pcsrc=11, mispredict=1 and ex_taken=0; the entry decrements.
REQ-025 SHALL cover saturation: five taken BLTU (cf=0) at 0x80 leave the entry at 11 (CTR_W=2); one not-taken takes it to 10 with if_pred_taken still 1.
REQ-026 SHALL cover jumps and invalid: JAL gives pcsrc=01 with mispredict=0; JALR gives 10; ex_valid=0 with op 01 gives 00 and leaves the BHT unchanged.
REQ-027 SHALL cover collision and counters: same-cycle if_pc=ex_pc returns the old prediction; with BPU_PERF_CNT_EN, 3 branches including 1 mispredict give perf_branches=3 and perf_mispred=1.
